// File: rtl/shift_sequencer_if.sv
// Request/response bundle between the ALU issue logic and the iterative shift unit.
// The master drives requests and accepts results; the slave is the shift unit.
interface shift_sequencer_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [4:0]       shamt;
    logic             amt_sel;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             busy;

    modport master (
        output in_valid, op, a, b, shamt, amt_sel, out_ready,
        input  in_ready, out_valid, result, busy
    );

    modport slave (
        input  in_valid, op, a, b, shamt, amt_sel, out_ready,
        output in_ready, out_valid, result, busy
    );
endinterface

// File: rtl/shift_sequencer.sv
// Iterative SLL/SRL/SRA/ROR unit that moves at most STEP bit positions per cycle.
// This replaces a full barrel shifter; the result is handed off on a valid/ready pair.
module shift_sequencer #(
    parameter int WIDTH = 32,
    parameter int STEP  = 4
) (
    input  logic               clk,
    input  logic               rst,
    shift_sequencer_if.slave   bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [4:0] STEP_L = 5'(STEP);

    state_t           state, state_n;
    logic [1:0]       op_q;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] shifted;
    logic [4:0]       rem;
    logic [4:0]       k;
    logic [4:0]       rem_next;
    logic [4:0]       amt;
    logic             unused_b_hi;

    // Only the low five bits of the register operand form the amount.
    assign unused_b_hi = ^bus.b[WIDTH-1:5];
    assign amt         = bus.amt_sel ? bus.b[4:0] : bus.shamt;
    assign k           = (rem < STEP_L) ? rem : STEP_L;
    assign rem_next    = rem - k;

    always_comb begin
        shifted = acc;
        unique case (op_q)
            2'b00: shifted = acc << k;
            2'b01: shifted = acc >> k;
            2'b10: shifted = $signed(acc) >>> k;
            2'b11: shifted = (acc >> k) | (acc << (6'(WIDTH) - {1'b0, k}));
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (bus.in_valid) state_n = (amt != 5'd0) ? SHIFT : DONE;
            SHIFT:   if (rem_next == 5'd0) state_n = DONE;
            DONE:    if (bus.out_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Operands are captured only on the accept edge; acc doubles as the result register.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q <= 2'b00;
            acc  <= '0;
            rem  <= 5'd0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        op_q <= bus.op;
                        acc  <= bus.a;
                        rem  <= amt;
                    end
                end
                SHIFT: begin
                    acc <= shifted;
                    rem <= rem_next;
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.busy      = (state != IDLE);
    assign bus.result    = acc;
endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer: directed cases on a STEP=4 unit plus a
// randomized sweep run in lockstep on STEP=1, 4 and 16 units against a reference model.
module tb_shift_sequencer;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic [4:0]  shamt = '0;
    logic        amt_sel = 1'b0;
    logic        out_ready = 1'b0;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    shift_sequencer_if #(.WIDTH(32)) bus1 ();
    shift_sequencer_if #(.WIDTH(32)) bus4 ();
    shift_sequencer_if #(.WIDTH(32)) bus16 ();

    assign bus1.in_valid  = in_valid;
    assign bus1.op        = op;
    assign bus1.a         = a;
    assign bus1.b         = b;
    assign bus1.shamt     = shamt;
    assign bus1.amt_sel   = amt_sel;
    assign bus1.out_ready = out_ready;

    assign bus4.in_valid  = in_valid;
    assign bus4.op        = op;
    assign bus4.a         = a;
    assign bus4.b         = b;
    assign bus4.shamt     = shamt;
    assign bus4.amt_sel   = amt_sel;
    assign bus4.out_ready = out_ready;

    assign bus16.in_valid  = in_valid;
    assign bus16.op        = op;
    assign bus16.a         = a;
    assign bus16.b         = b;
    assign bus16.shamt     = shamt;
    assign bus16.amt_sel   = amt_sel;
    assign bus16.out_ready = out_ready;

    shift_sequencer #(.WIDTH(32), .STEP(1))  dut1  (.clk(clk), .rst(rst), .bus(bus1));
    shift_sequencer #(.WIDTH(32), .STEP(4))  dut4  (.clk(clk), .rst(rst), .bus(bus4));
    shift_sequencer #(.WIDTH(32), .STEP(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16));

    function automatic logic [31:0] ref_shift(input logic [1:0] o, input logic [31:0] v, input int n);
        logic [31:0] r;
        case (o)
            2'b00:   r = v << n;
            2'b01:   r = v >> n;
            2'b10:   r = $signed(v) >>> n;
            default: r = (n == 0) ? v : ((v >> n) | (v << (32 - n)));
        endcase
        return r;
    endfunction

    function automatic int ref_latency(input int n, input int s);
        return (n + s - 1) / s + 1;
    endfunction

    // Presents one request for a single accept edge, then scrambles the inputs.
    task automatic issue(input logic [1:0] o, input logic [31:0] av, input logic [31:0] bv,
                         input logic [4:0] sh, input logic sel);
        op = o; a = av; b = bv; shamt = sh; amt_sel = sel;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        op = 2'($urandom); a = $urandom; b = $urandom; shamt = 5'($urandom); amt_sel = 1'($urandom);
    endtask

    task automatic wait_out4(output int lat);
        lat = 1;
        while (bus4.out_valid !== 1'b1 && lat < 60) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        tests_run++;
        if (bus4.in_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset_in_ready got %b want 1", bus4.in_ready); end
        tests_run++;
        if (bus4.out_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_out_valid got %b want 0", bus4.out_valid); end
        tests_run++;
        if (bus4.busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_busy got %b want 0", bus4.busy); end
        tests_run++;
        if (bus4.result !== 32'h0) begin tests_failed++; $display("[TB] FAIL reset_result got %h want 0", bus4.result); end
    endtask

    task automatic test_sll();
        int lat;
        out_ready = 1'b1;
        issue(2'b00, 32'h0000_0001, 32'h0000_001C, 5'd5, 1'b0);
        tests_run++;
        if (bus4.busy !== 1'b1 || bus4.in_ready !== 1'b0) begin
            tests_failed++; $display("[TB] FAIL sll_busy got busy=%b in_ready=%b want 1/0", bus4.busy, bus4.in_ready);
        end
        wait_out4(lat);
        tests_run++;
        if (lat !== 3) begin tests_failed++; $display("[TB] FAIL sll_latency got %0d want 3", lat); end
        tests_run++;
        if (bus4.result !== 32'h0000_0020) begin tests_failed++; $display("[TB] FAIL sll_result got %h want 00000020", bus4.result); end
        @(posedge clk); #1;
        tests_run++;
        if (bus4.in_ready !== 1'b1 || bus4.out_valid !== 1'b0) begin
            tests_failed++; $display("[TB] FAIL sll_return_idle got in_ready=%b out_valid=%b want 1/0", bus4.in_ready, bus4.out_valid);
        end
    endtask

    task automatic test_sra_srl();
        int lat;
        out_ready = 1'b1;
        issue(2'b10, 32'h8000_0000, 32'h0000_001F, 5'd3, 1'b1);
        wait_out4(lat);
        tests_run++;
        if (lat !== 9) begin tests_failed++; $display("[TB] FAIL sra_latency got %0d want 9", lat); end
        tests_run++;
        if (bus4.result !== 32'hFFFF_FFFF) begin tests_failed++; $display("[TB] FAIL sra_result got %h want ffffffff", bus4.result); end
        @(posedge clk); #1;
        issue(2'b01, 32'h8000_0000, 32'h0000_001F, 5'd3, 1'b1);
        wait_out4(lat);
        tests_run++;
        if (lat !== 9) begin tests_failed++; $display("[TB] FAIL srl_latency got %0d want 9", lat); end
        tests_run++;
        if (bus4.result !== 32'h0000_0001) begin tests_failed++; $display("[TB] FAIL srl_result got %h want 00000001", bus4.result); end
        @(posedge clk); #1;
    endtask

    task automatic test_zero_ror();
        int lat;
        out_ready = 1'b1;
        issue(2'b11, 32'hDEAD_BEEF, 32'h0000_0011, 5'd0, 1'b0);
        wait_out4(lat);
        tests_run++;
        if (lat !== 1) begin tests_failed++; $display("[TB] FAIL ror0_latency got %0d want 1", lat); end
        tests_run++;
        if (bus4.result !== 32'hDEAD_BEEF) begin tests_failed++; $display("[TB] FAIL ror0_result got %h want deadbeef", bus4.result); end
        @(posedge clk); #1;
        issue(2'b11, 32'h0000_0001, 32'h0000_0000, 5'd1, 1'b0);
        wait_out4(lat);
        tests_run++;
        if (lat !== 2) begin tests_failed++; $display("[TB] FAIL ror1_latency got %0d want 2", lat); end
        tests_run++;
        if (bus4.result !== 32'h8000_0000) begin tests_failed++; $display("[TB] FAIL ror1_result got %h want 80000000", bus4.result); end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        int lat;
        logic [31:0] av;
        logic [31:0] held;
        av = $urandom;
        out_ready = 1'b0;
        issue(2'b00, av, 32'h0, 5'd7, 1'b0);
        wait_out4(lat);
        held = bus4.result;
        tests_run++;
        if (held !== (av << 7)) begin tests_failed++; $display("[TB] FAIL bp_result got %h want %h", held, av << 7); end
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                op = 2'b01; a = 32'h1234_5678; shamt = 5'd3; amt_sel = 1'b0; in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk); #1;
            tests_run++;
            if (bus4.out_valid !== 1'b1 || bus4.result !== held || bus4.in_ready !== 1'b0) begin
                tests_failed++;
                $display("[TB] FAIL bp_hold cycle %0d got out_valid=%b result=%h in_ready=%b want 1/%h/0",
                         i, bus4.out_valid, bus4.result, bus4.in_ready, held);
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        tests_run++;
        if (bus4.in_ready !== 1'b1 || bus4.out_valid !== 1'b0) begin
            tests_failed++; $display("[TB] FAIL bp_release got in_ready=%b out_valid=%b want 1/0", bus4.in_ready, bus4.out_valid);
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        out_ready = 1'b1;
        issue(2'b01, 32'hF000_0000, 32'h0, 5'd12, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        tests_run++;
        if (bus4.in_ready !== 1'b1 || bus4.out_valid !== 1'b0 || bus4.result !== 32'h0) begin
            tests_failed++;
            $display("[TB] FAIL midreset got in_ready=%b out_valid=%b result=%h want 1/0/00000000",
                     bus4.in_ready, bus4.out_valid, bus4.result);
        end
        issue(2'b01, 32'hF000_0000, 32'h0, 5'd4, 1'b0);
        wait_out4(lat);
        tests_run++;
        if (lat !== 2) begin tests_failed++; $display("[TB] FAIL midreset_latency got %0d want 2", lat); end
        tests_run++;
        if (bus4.result !== 32'h0F00_0000) begin tests_failed++; $display("[TB] FAIL midreset_result got %h want 0f000000", bus4.result); end
        @(posedge clk); #1;
    endtask

    // All three units get the same request; each is timed and checked on its own.
    task automatic test_random_sweep();
        do_reset();
        out_ready = 1'b1;
        for (int o = 0; o < 4; o++) begin
            for (int n = 0; n < 32; n++) begin
                int guard;
                int c;
                int lat1, lat4, lat16;
                logic [31:0] r1, r4, r16, av, exp_r;
                logic sel;
                guard = 0;
                while (!(bus1.in_ready === 1'b1 && bus4.in_ready === 1'b1 && bus16.in_ready === 1'b1) && guard < 50) begin
                    @(posedge clk); #1;
                    guard++;
                end
                tests_run++;
                if (guard >= 50) begin
                    tests_failed++; $display("[TB] FAIL sweep_idle_timeout op=%0d n=%0d", o, n);
                end
                av = $urandom;
                sel = 1'($urandom);
                if (sel)
                    issue(2'(o), av, {27'($urandom), 5'(n)}, 5'($urandom), 1'b1);
                else
                    issue(2'(o), av, $urandom, 5'(n), 1'b0);
                lat1 = -1; lat4 = -1; lat16 = -1;
                r1 = 'x; r4 = 'x; r16 = 'x;
                c = 1;
                while (c <= 40 && (lat1 < 0 || lat4 < 0 || lat16 < 0)) begin
                    if (lat1 < 0 && bus1.out_valid === 1'b1) begin lat1 = c; r1 = bus1.result; end
                    if (lat4 < 0 && bus4.out_valid === 1'b1) begin lat4 = c; r4 = bus4.result; end
                    if (lat16 < 0 && bus16.out_valid === 1'b1) begin lat16 = c; r16 = bus16.result; end
                    if (lat1 < 0 || lat4 < 0 || lat16 < 0) begin
                        @(posedge clk); #1;
                        c++;
                    end
                end
                exp_r = ref_shift(2'(o), av, n);
                tests_run++;
                if (r1 !== exp_r) begin tests_failed++; $display("[TB] FAIL sweep_result_s1 op=%0d n=%0d a=%h got %h want %h", o, n, av, r1, exp_r); end
                tests_run++;
                if (r4 !== exp_r) begin tests_failed++; $display("[TB] FAIL sweep_result_s4 op=%0d n=%0d a=%h got %h want %h", o, n, av, r4, exp_r); end
                tests_run++;
                if (r16 !== exp_r) begin tests_failed++; $display("[TB] FAIL sweep_result_s16 op=%0d n=%0d a=%h got %h want %h", o, n, av, r16, exp_r); end
                tests_run++;
                if (lat1 != ref_latency(n, 1)) begin tests_failed++; $display("[TB] FAIL sweep_latency_s1 op=%0d n=%0d got %0d want %0d", o, n, lat1, ref_latency(n, 1)); end
                tests_run++;
                if (lat4 != ref_latency(n, 4)) begin tests_failed++; $display("[TB] FAIL sweep_latency_s4 op=%0d n=%0d got %0d want %0d", o, n, lat4, ref_latency(n, 4)); end
                tests_run++;
                if (lat16 != ref_latency(n, 16)) begin tests_failed++; $display("[TB] FAIL sweep_latency_s16 op=%0d n=%0d got %0d want %0d", o, n, lat16, ref_latency(n, 16)); end
            end
        end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_sll();
        test_sra_srl();
        test_zero_ror();
        test_backpressure();
        test_reset_mid();
        test_random_sweep();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
